// File: rtl/deser2_capture_pkg.sv
// Shared types and helpers for the DEMUX2-driven 1:2 deserializer.
// Lane numbering matches the DEMUX2 select: S=0 routes D to Y0, S=1 to Y1.
package deser2_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        LANE_Y0 = 1'b0,
        LANE_Y1 = 1'b1
    } lane_e;

    // Even bit positions travel on Y0, odd positions on Y1.
    function automatic lane_e lane_of(input int unsigned idx);
        lane_e lane;
        if (idx[0]) begin
            lane = LANE_Y1;
        end else begin
            lane = LANE_Y0;
        end
        return lane;
    endfunction

endpackage

// File: rtl/deser2_capture_if.sv
// Bit-in / word-out valid-ready bundle of the deserializer.
interface deser2_capture_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/deser2_capture_chk.sv
// Simulation-only check: the lane selected by sel must carry a defined value on accept.
module deser2_capture_chk (
    input logic clk,
    input logic rst_n,
    input logic acc,
    input logic sel,
    input logic y0,
    input logic y1
);

    logic lane_s;

    // Only the selected lane is examined; the other one floats by design.
    always_comb begin
        if (sel) begin
            lane_s = y1;
        end else begin
            lane_s = y0;
        end
    end

    a_lane_known: assert property (@(posedge clk) disable iff (!rst_n)
        acc |-> !$isunknown(lane_s));

endmodule

// File: rtl/deser2_out_slot.sv
// Single-entry holding register for a completed word with valid/ready drain.
// A load in the same cycle as a drain replaces the word and keeps valid high.
module deser2_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
);

    // Word holding register and its valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= {WIDTH{1'b0}};
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/deser2_capture.sv
// Drives the DEMUX2 select and reassembles its two output lanes into LSB-first words.
module deser2_capture
    import deser2_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    deser2_capture_if.slave  bus,
    output logic             sel_o,
    input  logic             y0_i,
    input  logic             y1_i
);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] idx_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] word_s;
    logic             acc_s;
    logic             last_s;
    logic             lane_bit_s;
    logic             load_s;

    // Handshake: only the final bit of a word can be held off by a full slot.
    always_comb begin
        last_s       = (idx_r == IDX_LAST);
        bus.in_ready = !(last_s && bus.out_valid && !bus.out_ready);
        acc_s        = bus.in_valid && bus.in_ready;
        load_s       = acc_s && last_s;
    end

    // Lane mux keyed by the registered select, so the floating lane is never looked at.
    always_comb begin
        case (lane_e'(sel_o))
            LANE_Y0: lane_bit_s = y0_i;
            LANE_Y1: lane_bit_s = y1_i;
            default: lane_bit_s = y0_i;
        endcase
    end

    // Next bit index and the completed word as it would load this cycle.
    always_comb begin
        if (last_s) begin
            idx_nxt_s = {CNT_W{1'b0}};
        end else begin
            idx_nxt_s = idx_r + CNT_W'(1);
        end
        word_s            = shreg_r;
        word_s[WIDTH-1]   = lane_bit_s;
    end

    // Bit index, select flop and in-place capture register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r   <= {CNT_W{1'b0}};
            sel_o   <= 1'b0;
            shreg_r <= {WIDTH{1'b0}};
        end else if (acc_s) begin
            idx_r          <= idx_nxt_s;
            sel_o          <= lane_of(int'(idx_nxt_s));
            shreg_r[idx_r] <= lane_bit_s;
        end else begin
            idx_r <= idx_r;
            sel_o <= sel_o;
        end
    end

    deser2_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (word_s),
        .data      (bus.out_data),
        .valid     (bus.out_valid),
        .ready     (bus.out_ready)
    );

endmodule

// File: tb/tb_deser2_capture.sv
// Scoreboard bench: a DEMUX2 model sits between the serial stimulus and the DUT lanes.
module tb_deser2_capture;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic d;
    logic sel;
    wire  y0;
    wire  y1;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_mode = 1'b0;

    logic [W-1:0] expq[$];
    int           m_cnt = 0;
    logic [W-1:0] m_word = '0;

    deser2_capture_if #(.WIDTH(W)) bus ();

    // DEMUX2 transmission-gate cell: the unselected output floats.
    assign y0 = sel ? 1'bz : d;
    assign y1 = sel ? d : 1'bz;

    deser2_capture #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sel_o (sel),
        .y0_i  (y0),
        .y1_i  (y1)
    );

    deser2_capture_chk chk (
        .clk   (clk),
        .rst_n (rst_n),
        .acc   (bus.in_valid & bus.in_ready),
        .sel   (sel),
        .y0    (y0),
        .y1    (y1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/reference model: words are whatever bits were accepted, 8 at a time, LSB first.
    always @(negedge clk) begin
        bit pend;
        bit exp_ready;
        if (!rst_n) begin
            expq.delete();
            m_cnt  = 0;
            m_word = '0;
        end else begin
            pend      = (expq.size() > 0);
            exp_ready = !(m_cnt == W - 1 && pend && !bus.out_ready);
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, pend});
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
            if (pend) check("out_data", {24'd0, bus.out_data}, {24'd0, expq[0]});
            if (pend && bus.out_ready) void'(expq.pop_front());
            if (bus.in_valid && exp_ready) begin
                check("sel", {31'd0, sel}, m_cnt % 2);
                m_word[m_cnt] = d;
                m_cnt++;
                if (m_cnt == W) begin
                    expq.push_back(m_word);
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        d = 1'bx;
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b);
        bit acc = 1'b0;
        int waited = 0;
        bus.in_valid = 1'b1;
        d = b;
        while (!acc) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            step();
            waited++;
            if (!acc && waited > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: bit not accepted after %0d cycles", waited);
                break;
            end
        end
        bus.in_valid = 1'b0;
        d = 1'bx;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gaps);
        for (int k = 0; k < W; k++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
            send_bit(w[k]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        d = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel", {31'd0, sel}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        send_word(8'hA5, 1'b0);
        idle(4);

        send_word(8'h3C, 1'b0);
        send_word(8'hC3, 1'b0);
        idle(4);

        // Back-pressure: hold 8'hFF, the final bit of 8'h01 must stall.
        send_word(8'hFF, 1'b0);
        bus.out_ready = 1'b0;
        fork
            send_word(8'h01, 1'b0);
            begin
                repeat (15) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(4);

        // Reset mid-word drops the partial bits.
        for (int k = 0; k < 5; k++) send_bit(1'($urandom_range(0, 1)));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(8'h5A, 1'b0);
        idle(4);

        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) send_word(8'($urandom_range(0, 255)), 1'b1);
        rnd_mode = 1'b0;
        bus.out_ready = 1'b1;
        idle(30);

        check("all_words_drained", expq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
